// File: rtl/kmu_cta_gen.sv
// rtl/kmu_cta_gen.sv - KMU CTA generator: walks a launch grid x-fastest and emits one CTA task per handshake
// Optional feature macro: KMU_PERF_EN (adds perf_stall_cycles / perf_ctas counters)
module kmu_cta_gen #(
  parameter int XLEN        = 32,
  parameter int NUM_THREADS = 4,
  parameter int NUM_WARPS   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   launch_valid,
  output logic                   launch_ready,
  input  logic [XLEN-1:0]        launch_pc,
  input  logic [XLEN-1:0]        launch_param,
  input  logic [31:0]            grid_x,
  input  logic [31:0]            grid_y,
  input  logic [31:0]            grid_z,
  input  logic [31:0]            block_threads,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [XLEN-1:0]        req_start_pc,
  output logic [XLEN-1:0]        req_param,
  output logic [31:0]            req_cta_x,
  output logic [31:0]            req_cta_y,
  output logic [31:0]            req_cta_z,
  output logic [31:0]            req_cta_id,
  output logic [NUM_THREADS-1:0] req_remain_mask,
  output logic [31:0]            req_num_warps,
  output logic                   busy,
  output logic                   done
`ifdef KMU_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_ctas
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GEN  = 1'b1;
  localparam logic [31:0] MAX_THREADS = 32'(NUM_WARPS * NUM_THREADS);

  logic [0:0]            state;
  logic [31:0]           gx, gy, gz;
  logic [31:0]           bt, rem;
  logic [31:0]           new_warps;
  logic [NUM_THREADS-1:0] new_mask;
  logic                  launch_fire, req_fire;
  logic                  x_last, y_last, z_last;
  logic                  zero_launch;

  assign launch_ready = (state == ST_IDLE);
  assign req_valid    = (state == ST_GEN);
  assign busy         = (state == ST_GEN);
  assign launch_fire  = launch_valid && launch_ready;
  assign req_fire     = req_valid && req_ready;
  assign x_last       = (req_cta_x == gx - 32'd1);
  assign y_last       = (req_cta_y == gy - 32'd1);
  assign z_last       = (req_cta_z == gz - 32'd1);
  assign zero_launch  = (grid_x == 32'd0) || (grid_y == 32'd0) ||
                        (grid_z == 32'd0) || (block_threads == 32'd0);

  // Clamp the block to what one core can hold, then derive warp count and last-warp lane mask
  always_comb begin
    bt        = (block_threads > MAX_THREADS) ? MAX_THREADS : block_threads;
    rem       = bt % 32'(NUM_THREADS);
    new_warps = (bt + 32'(NUM_THREADS - 1)) / 32'(NUM_THREADS);
    new_mask  = (rem == 32'd0) ? {NUM_THREADS{1'b1}} : ~({NUM_THREADS{1'b1}} << rem);
  end

  // Launch capture, grid walk and completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      gx              <= '0;
      gy              <= '0;
      gz              <= '0;
      req_start_pc    <= '0;
      req_param       <= '0;
      req_cta_x       <= '0;
      req_cta_y       <= '0;
      req_cta_z       <= '0;
      req_cta_id      <= '0;
      req_remain_mask <= '0;
      req_num_warps   <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch_fire) begin
            gx              <= grid_x;
            gy              <= grid_y;
            gz              <= grid_z;
            req_start_pc    <= launch_pc;
            req_param       <= launch_param;
            req_cta_x       <= '0;
            req_cta_y       <= '0;
            req_cta_z       <= '0;
            req_cta_id      <= '0;
            req_remain_mask <= new_mask;
            req_num_warps   <= new_warps;
            // An empty grid completes immediately without emitting any CTA
            if (zero_launch) done  <= 1'b1;
            else             state <= ST_GEN;
          end
        end
        default: begin
          if (req_fire) begin
            if (x_last && y_last && z_last) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              req_cta_id <= req_cta_id + 32'd1;
              if (x_last) begin
                req_cta_x <= '0;
                if (y_last) begin
                  req_cta_y <= '0;
                  req_cta_z <= req_cta_z + 32'd1;
                end else begin
                  req_cta_y <= req_cta_y + 32'd1;
                end
              end else begin
                req_cta_x <= req_cta_x + 32'd1;
              end
            end
          end
        end
      endcase
    end
  end

`ifdef KMU_PERF_EN
  // Per-launch stall and issued-CTA counters; stall count saturates rather than wraps
  always_ff @(posedge clk) begin
    if (reset || launch_fire) begin
      perf_stall_cycles <= '0;
      perf_ctas         <= '0;
    end else begin
      if (req_valid && !req_ready && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (req_fire)
        perf_ctas <= perf_ctas + 32'd1;
    end
  end
`endif

endmodule
